// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage constants and next-PC select encoding
package cpu_pkg;
  localparam int INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
  typedef enum logic [1:0] {
    PCSEL_SEQ = 2'd0,
    PCSEL_JR  = 2'd1,
    PCSEL_BR  = 2'd2,
    PCSEL_J   = 2'd3
  } pc_sel_e;
endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel: prioritised redirect selection (jr > branch > jump), targets word-aligned
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_target,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] ifid_pc_plus4,
  output logic [31:0] next_pc,
  output logic        redirect
);
  pc_sel_e     sel;
  logic [31:0] target;
  always_comb begin
    sel = jump_reg ? PCSEL_JR : branch ? PCSEL_BR : jump ? PCSEL_J : PCSEL_SEQ;
    target = sel == PCSEL_JR ? jump_reg_target :
             sel == PCSEL_BR ? branch_target :
             sel == PCSEL_J  ? {ifid_pc_plus4[31:28], jump_index, 2'b00} : pc_plus4;
    next_pc = {target[31:2], 2'b00};
    redirect = sel != PCSEL_SEQ;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection and IF/ID pipeline register with fetch counter
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF,
  parameter int          CNT_W    = 32
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               Branch,
  input  logic [31:0]        BranchTarget,
  input  logic               Jump,
  input  logic [25:0]        JumpIndex,
  input  logic               JumpReg,
  input  logic [31:0]        JumpRegTarget,
  input  logic [INSTR_W-1:0] Instruction,
  output logic [31:0]        PCAddress,
  output logic [INSTR_W-1:0] IFID_Instruction,
  output logic [31:0]        IFID_PCPlus4,
  output logic               IFID_Valid,
  output logic [CNT_W-1:0]   FetchCount
);
  logic [31:0]        pc_q, pc_d, pc_plus4, redir_pc;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        pc4_q, pc4_d;
  logic               valid_q, valid_d, redirect, squash, accept;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  next_pc_sel u_sel (
    .jump_reg        (JumpReg),
    .jump_reg_target (JumpRegTarget),
    .branch          (Branch),
    .branch_target   (BranchTarget),
    .jump            (Jump),
    .jump_index      (JumpIndex),
    .pc_plus4        (pc_plus4),
    .ifid_pc_plus4   (pc4_q),
    .next_pc         (redir_pc),
    .redirect        (redirect)
  );

  // a redirect beats Stall for the PC, and also squashes the instruction behind it
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    squash = Flush | redirect;
    accept = !squash && !Stall;
    pc_d = redirect ? redir_pc : Stall ? pc_q : pc_plus4;
    instr_d = squash ? NOP_WORD : accept ? Instruction : instr_q;
    pc4_d = (squash || accept) ? pc_plus4 : pc4_q;
    valid_d = squash ? 1'b0 : accept ? 1'b1 : valid_q;
    cnt_d = accept ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q <= '0;
      valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      instr_q <= instr_d;
      pc4_q <= pc4_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
    end
  end

  assign PCAddress = pc_q;
  assign IFID_Instruction = instr_q;
  assign IFID_PCPlus4 = pc4_q;
  assign IFID_Valid = valid_q;
  assign FetchCount = cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of sequencing, redirects, stall/flush, async reset and PC wrap
module tb_fetch_stage;
  logic        Clk = 1'b0, Reset = 1'b1, Stall = 1'b0, Flush = 1'b0;
  logic        Branch = 1'b0, Jump = 1'b0, JumpReg = 1'b0;
  logic [31:0] BranchTarget = '0, JumpRegTarget = '0, Instruction;
  logic [25:0] JumpIndex = '0;
  logic [31:0] PCAddress, IFID_Instruction, IFID_PCPlus4, FetchCount;
  logic        IFID_Valid;
  int          total = 0, bad = 0;

  fetch_stage dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .Branch(Branch), .BranchTarget(BranchTarget), .Jump(Jump), .JumpIndex(JumpIndex),
    .JumpReg(JumpReg), .JumpRegTarget(JumpRegTarget), .Instruction(Instruction),
    .PCAddress(PCAddress), .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4),
    .IFID_Valid(IFID_Valid), .FetchCount(FetchCount)
  );

  always #5 Clk = ~Clk;
  // instruction memory: mem[i] = i*4, so the word at byte address A is A
  assign Instruction = PCAddress;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_in();
    Stall = 0; Flush = 0; Branch = 0; Jump = 0; JumpReg = 0;
  endtask

  task automatic do_reset();
    clear_in();
    Reset = 1;
    step();
    Reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    Reset = 1;
    #1;
    total++;
    if ({PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount} !== {32'h0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL reset: pc=%h ins=%h pc4=%h v=%b cnt=%0d want all zero", PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount);
    end
    Reset = 0;
  endtask

  task automatic test_sequential();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step();
      total++;
      if ({PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount} !== {32'(4*k), 32'(4*(k-1)), 32'(4*k), 1'b1, 32'(k)}) begin
        bad++;
        $display("FAIL seq%0d: pc=%h ins=%h pc4=%h v=%b cnt=%0d want pc=%h ins=%h pc4=%h v=1 cnt=%0d",
                 k, PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount, 4*k, 4*(k-1), 4*k, k);
      end
    end
  endtask

  task automatic test_jump();
    do_reset();
    step();
    step();
    Jump = 1; JumpIndex = 26'd4;
    step();
    clear_in();
    total++;
    if ({PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount} !== {32'h10, 32'h0, 32'hC, 1'b0, 32'd2}) begin
      bad++;
      $display("FAIL jump: pc=%h ins=%h pc4=%h v=%b cnt=%0d want 10/0/c/0/2", PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount);
    end
    step();
    total++;
    if ({PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount} !== {32'h14, 32'h10, 32'h14, 1'b1, 32'd3}) begin
      bad++;
      $display("FAIL jump_fetch: pc=%h ins=%h pc4=%h v=%b cnt=%0d want 14/10/14/1/3", PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount);
    end
  endtask

  task automatic test_priority();
    Branch = 1; Jump = 1; JumpReg = 1; BranchTarget = 32'h38; JumpRegTarget = 32'h3F; JumpIndex = 26'd4;
    step();
    clear_in();
    total++;
    if ({PCAddress, IFID_Instruction, IFID_Valid, FetchCount} !== {32'h3C, 32'h0, 1'b0, 32'd3}) begin
      bad++;
      $display("FAIL priority: pc=%h ins=%h v=%b cnt=%0d want 3c/0/0/3", PCAddress, IFID_Instruction, IFID_Valid, FetchCount);
    end
    Branch = 1; Jump = 1; BranchTarget = 32'h39;
    step();
    clear_in();
    total++;
    if (PCAddress !== 32'h38) begin
      bad++;
      $display("FAIL br_over_j: pc=%h want 38", PCAddress);
    end
  endtask

  task automatic test_stall();
    do_reset();
    JumpReg = 1; JumpRegTarget = 32'h1C;
    step();
    clear_in();
    step();
    total++;
    if ({PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount} !== {32'h20, 32'h1C, 32'h20, 1'b1, 32'd1}) begin
      bad++;
      $display("FAIL pre_stall: pc=%h ins=%h pc4=%h v=%b cnt=%0d want 20/1c/20/1/1", PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount);
    end
    Stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if ({PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount} !== {32'h20, 32'h1C, 32'h20, 1'b1, 32'd1}) begin
        bad++;
        $display("FAIL stall%0d: pc=%h ins=%h pc4=%h v=%b cnt=%0d want 20/1c/20/1/1", k, PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount);
      end
    end
    Branch = 1; BranchTarget = 32'h40;
    step();
    clear_in();
    total++;
    if ({PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount} !== {32'h40, 32'h0, 32'h24, 1'b0, 32'd1}) begin
      bad++;
      $display("FAIL stall_branch: pc=%h ins=%h pc4=%h v=%b cnt=%0d want 40/0/24/0/1", PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount);
    end
  endtask

  task automatic test_flush();
    Flush = 1;
    step();
    clear_in();
    total++;
    if ({PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount} !== {32'h44, 32'h0, 32'h44, 1'b0, 32'd1}) begin
      bad++;
      $display("FAIL flush: pc=%h ins=%h pc4=%h v=%b cnt=%0d want 44/0/44/0/1", PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount);
    end
  endtask

  task automatic test_async_reset();
    JumpReg = 1; JumpRegTarget = 32'h2C;
    step();
    clear_in();
    step();
    total++;
    if ({PCAddress, IFID_Valid} !== {32'h30, 1'b1}) begin
      bad++;
      $display("FAIL pre_areset: pc=%h v=%b want 30/1", PCAddress, IFID_Valid);
    end
    @(negedge Clk);
    #2 Reset = 1;
    #1;
    total++;
    if ({PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount} !== {32'h0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL async_reset: pc=%h ins=%h pc4=%h v=%b cnt=%0d want all zero", PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount);
    end
    step();
    Reset = 0;
  endtask

  task automatic test_wrap();
    do_reset();
    JumpReg = 1; JumpRegTarget = 32'hFFFF_FFFE;
    step();
    clear_in();
    total++;
    if (PCAddress !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_load: pc=%h want fffffffc", PCAddress);
    end
    step();
    total++;
    if ({PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount} !== {32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd1}) begin
      bad++;
      $display("FAIL wrap: pc=%h ins=%h pc4=%h v=%b cnt=%0d want 0/fffffffc/0/1/1", PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_priority();
    test_stall();
    test_flush();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the instruction memory.
- Holds the program counter and drives the word-aligned fetch address into the instruction memory.
- Captures the returned instruction and PC+4 into the IF/ID pipeline register.
- Selects next PC from sequential, branch, jump and jump-register sources; supports stall and flush from the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
- NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset
- CNT_W, 32, width of the fetched-instruction performance counter

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Stall  in  1  hold PC and IF/ID contents
- Flush  in  1  squash IF/ID contents (insert NOP_WORD, Valid=0)
- Branch  in  1  taken conditional branch resolved in ID
- BranchTarget  in  32  byte address of branch target
- Jump  in  1  j/jal resolved in ID
- JumpIndex  in  26  instr[25:0] of the jump
- JumpReg  in  1  jr resolved in ID
- JumpRegTarget  in  32  register value for jr
- Instruction  in  32  word returned by instruction memory for PCAddress (combinational)
- PCAddress  out  32  current PC; fetch address to instruction memory
- IFID_Instruction  out  32  registered instruction
- IFID_PCPlus4  out  32  registered PC+4 of that instruction
- IFID_Valid  out  1  IF/ID holds a real instruction
- FetchCount  out  CNT_W  number of instructions accepted into IF/ID since reset

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-redirect):
  - PCAddress=RESET_PC, IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0, FetchCount=0.
- PCPlus4 = PCAddress + 32'd4, computed internally, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Jump target = {IFID_PCPlus4[31:28], JumpIndex, 2'b00}.
- Redirect priority, highest first: JumpReg, Branch, Jump. Exactly one target is chosen when several assert together.
- All targets have bits [1:0] forced to 0 before being loaded into the PC. Misaligned inputs are silently aligned; no exception is raised.
- Next-PC on the rising edge:
  - Any redirect -> selected target (redirect overrides Stall).
  - Otherwise Stall=1 -> PC holds.
  - Otherwise -> PCPlus4.
- IF/ID update on the rising edge, first matching rule wins:
  1. Flush=1, or any redirect: IFID_Instruction=NOP_WORD, IFID_Valid=0, IFID_PCPlus4=PCPlus4. The delay-slot instruction is squashed; no architectural delay slot.
  2. Stall=1: all IF/ID registers hold.
  3. Otherwise: IFID_Instruction=Instruction, IFID_PCPlus4=PCPlus4, IFID_Valid=1.
- FetchCount increments by 1 only on rule 3 edges. It wraps at 2^CNT_W.
- Latency: the instruction at address A appears on IFID_Instruction one edge after PCAddress=A, provided that edge is unstalled and unflushed.
- The redirect penalty is one bubble cycle.
- PCAddress is a register output with no combinational path from any input, so the instruction memory path carries no loop.

Decomposition:
- Shared package (cpu_pkg) holds:
  - RESET_PC default
  - NOP_WORD
  - PC select encoding (PCSEL_SEQ=2'd0, PCSEL_JR=2'd1, PCSEL_BR=2'd2, PCSEL_J=2'd3)
  - INSTR_W=32
- One sub-module: next_pc_sel. It is combinational and takes the redirect inputs, PCPlus4 and IFID_PCPlus4, and returns the next PC plus a redirect flag.
- The PC register, IF/ID register and counter live in fetch_stage.

Test Plan:
1. Reset then release, no redirects, instruction memory returns mem[i]=i*4:
   - PCAddress sequences 0,4,8,...
   - IFID_Instruction lags one edge (0,4,8).
   - IFID_Valid=1 from the first edge.
   - FetchCount=5 after 5 edges.
2. Jump with IFID_PCPlus4=0x0000_0008, JumpIndex=26'd4:
   - Next PCAddress=0x10.
   - IF/ID gets NOP_WORD with Valid=0.
   - Next edge fetches 0x10.
3. Branch=1, Jump=1, JumpReg=1 together, with BranchTarget=0x38, JumpRegTarget=0x3F:
   - PCAddress=0x3C (JumpReg wins, aligned).
   - IF/ID squashed.
4. Stall=1 for 3 cycles at PC=0x20:
   - PCAddress, IFID_* and FetchCount all hold.
   - Stall with Branch=1 (target 0x40) -> PC=0x40, IF/ID squashed.
5. Reset asserted asynchronously mid-cycle at PC=0x30 with Valid=1:
   - Outputs go to reset values immediately, before the next clock edge.
6. Wrap-around: force PC to 0xFFFF_FFFC and run one unstalled edge:
   - PCAddress=0.
   - IFID_PCPlus4=0.
